// File: rtl/csw_recorder.sv
// rtl/csw_recorder.sv - CSW1 tape recorder: samples audio, RLE-encodes pulses, writes image to RAM
module csw_recorder #(
    parameter int                    ADDR_WIDTH = 25,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 25'h200000,
    parameter logic [ADDR_WIDTH-1:0] MAX_SIZE   = 25'h100000,
    parameter int                    CLK_HZ     = 28000000,
    parameter int                    SAMPLE_HZ  = 44100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  recording,
    input  logic                  audio_in,
    input  logic                  iocycle,
    output logic                  wr,
    output logic [ADDR_WIDTH-1:0] a,
    output logic [7:0]            d,
    output logic [ADDR_WIDTH-1:0] size,
    output logic                  busy,
    output logic                  overflow
);

    localparam logic [31:0]  SAMPLE_INC = 32'(SAMPLE_HZ);
    localparam logic [31:0]  CLK_LIM    = 32'(CLK_HZ);
    localparam logic [15:0]  RATE16     = 16'(SAMPLE_HZ);
    localparam logic [175:0] SIGNATURE  = "Compressed Square Wave";

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_RECORD, S_FLUSH} state_t;

    state_t      state;
    logic        audio_s1, audio_s2;
    logic        rec_d, iocycle_d;
    logic [31:0] acc, acc_sum;
    logic        tick;
    logic [31:0] run;
    logic        last, pol;
    logic [5:0]  hdr_idx;
    logic        emit_req;
    logic [31:0] emit_run;

    logic [7:0]  fifo_mem [16];
    logic [3:0]  wr_ptr, rd_ptr;
    logic [4:0]  fifo_count, fifo_free;

    logic        rec_rise, rec_fall, io_rise, io_fall;
    logic        hdr_pending, byte_avail, at_cap;
    logic        consume, discard, advance, pop, hdr_adv;
    logic [2:0]  push_n;
    logic        push_ok, push_drop;
    logic [7:0]  push_byte [5];
    logic [7:0]  hdr_byte;

    function automatic logic [7:0] hdr_rom(input logic [4:0] idx, input logic p);
        logic [7:0] b;
        b = 8'h00;
        if (idx < 5'd22) begin
            b = SIGNATURE[8*(21 - int'(idx)) +: 8];
        end else begin
            case (idx)
                5'd22:   b = 8'h1A;
                5'd23:   b = 8'h01;
                5'd24:   b = 8'h01;
                5'd25:   b = RATE16[7:0];
                5'd26:   b = RATE16[15:8];
                5'd27:   b = 8'h01;
                5'd28:   b = {7'b0, p};
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

    assign acc_sum     = acc + SAMPLE_INC;
    assign tick        = (acc_sum >= CLK_LIM);
    assign rec_rise    = recording & ~rec_d;
    assign rec_fall    = ~recording & rec_d;
    assign io_rise     = iocycle & ~iocycle_d;
    assign io_fall     = ~iocycle & iocycle_d;
    assign hdr_pending = (state != S_IDLE) && !hdr_idx[5];
    assign byte_avail  = hdr_pending || (fifo_count != 5'd0);
    assign at_cap      = (size >= MAX_SIZE);
    assign hdr_byte    = hdr_rom(hdr_idx[4:0], pol);

    // At capacity, pending bytes are retired without a write so the flush can still finish.
    assign consume   = io_fall & wr;
    assign discard   = at_cap & ~wr & byte_avail;
    assign advance   = consume | discard;
    assign hdr_adv   = advance & hdr_pending;
    assign pop       = advance & ~hdr_pending;
    assign fifo_free = 5'd16 - fifo_count + 5'(pop);

    always_comb begin
        push_n = 3'd0;
        if (emit_req) begin
            if (emit_run > 32'd255)
                push_n = 3'd5;
            else if (emit_run != 32'd0)
                push_n = 3'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < 5; i++) push_byte[i] = 8'h00;
        if (push_n == 3'd5) begin
            push_byte[1] = emit_run[7:0];
            push_byte[2] = emit_run[15:8];
            push_byte[3] = emit_run[23:16];
            push_byte[4] = emit_run[31:24];
        end else begin
            push_byte[0] = emit_run[7:0];
        end
    end

    // A long-run emit is all-or-nothing so the stream never holds a truncated record.
    assign push_ok   = (push_n != 3'd0) && ({2'b0, push_n} <= fifo_free);
    assign push_drop = (push_n != 3'd0) && !push_ok;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            for (int i = 0; i < 5; i++) begin
                if (3'(i) < push_n)
                    fifo_mem[wr_ptr + 4'(i)] <= push_byte[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            audio_s1   <= 1'b0;
            audio_s2   <= 1'b0;
            rec_d      <= 1'b0;
            iocycle_d  <= 1'b0;
            acc        <= 32'd0;
            run        <= 32'd0;
            last       <= 1'b0;
            pol        <= 1'b0;
            hdr_idx    <= 6'd0;
            emit_req   <= 1'b0;
            emit_run   <= 32'd0;
            wr_ptr     <= 4'd0;
            rd_ptr     <= 4'd0;
            fifo_count <= 5'd0;
            wr         <= 1'b0;
            a          <= BASE_ADDR;
            d          <= 8'h00;
            size       <= '0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            audio_s1  <= audio_in;
            audio_s2  <= audio_s1;
            rec_d     <= recording;
            iocycle_d <= iocycle;
            acc       <= tick ? acc_sum - CLK_LIM : acc_sum;
            emit_req  <= 1'b0;

            if (push_ok)
                wr_ptr <= wr_ptr + 4'(push_n);
            if (pop)
                rd_ptr <= rd_ptr + 4'd1;
            fifo_count <= fifo_count + 5'(push_ok ? push_n : 3'd0) - 5'(pop);
            if (push_drop || discard)
                overflow <= 1'b1;
            if (hdr_adv)
                hdr_idx <= hdr_idx + 6'd1;

            if (consume) begin
                size <= size + 1'b1;
                wr   <= 1'b0;
            end else if (io_rise && byte_avail && !at_cap && !wr) begin
                wr <= 1'b1;
                a  <= BASE_ADDR + size;
                d  <= hdr_pending ? hdr_byte : fifo_mem[rd_ptr];
            end

            case (state)
                S_IDLE: begin
                    if (rec_rise) begin
                        state    <= S_HEADER;
                        size     <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        hdr_idx  <= 6'd0;
                        pol      <= audio_s2;
                        last     <= audio_s2;
                        run      <= 32'd0;
                        acc      <= 32'd0;
                    end
                end
                S_HEADER, S_RECORD: begin
                    if (rec_fall) begin
                        state    <= S_FLUSH;
                        emit_req <= 1'b1;
                        emit_run <= run;
                    end else begin
                        if (state == S_HEADER && hdr_idx[5])
                            state <= S_RECORD;
                        if (tick) begin
                            if (audio_s2 != last) begin
                                emit_req <= 1'b1;
                                emit_run <= run;
                                run      <= 32'd1;
                                last     <= audio_s2;
                            end else if (run != 32'hFFFF_FFFF) begin
                                run <= run + 32'd1;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    if (!hdr_pending && !emit_req && fifo_count == 5'd0 && !wr) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csw_recorder.sv
// tb/tb_csw_recorder.sv - scoreboard bench for csw_recorder
module tb_csw_recorder;

    localparam logic [24:0] BASE = 25'h200000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        recording = 1'b0;
    logic        recording2 = 1'b0;
    logic        audio_in = 1'b1;
    logic        iocycle = 1'b0;
    logic        wr, wr2, busy, busy2, overflow, overflow2;
    logic [24:0] a, a2, size, size2;
    logic [7:0]  d, d2;

    always #5 clk = ~clk;

    csw_recorder #(
        .ADDR_WIDTH(25), .BASE_ADDR(BASE), .MAX_SIZE(25'h100000),
        .CLK_HZ(100), .SAMPLE_HZ(10)
    ) dut (
        .clk(clk), .reset(reset), .recording(recording), .audio_in(audio_in),
        .iocycle(iocycle), .wr(wr), .a(a), .d(d), .size(size), .busy(busy),
        .overflow(overflow)
    );

    csw_recorder #(
        .ADDR_WIDTH(25), .BASE_ADDR(BASE), .MAX_SIZE(25'd34),
        .CLK_HZ(100), .SAMPLE_HZ(10)
    ) dut_cap (
        .clk(clk), .reset(reset), .recording(recording2), .audio_in(audio_in),
        .iocycle(iocycle), .wr(wr2), .a(a2), .d(d2), .size(size2), .busy(busy2),
        .overflow(overflow2)
    );

    typedef struct {
        int              gap;
        int              nb;
        logic [4:0][7:0] b;
    } seg_t;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    int         wcount = 0;
    int         cap_wcount = 0;
    bit         io_en = 1'b0;

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_header(input logic p);
        string sig;
        sig = "Compressed Square Wave";
        for (int i = 0; i < 22; i++) exp_q.push_back(sig[i]);
        exp_q.push_back(8'h1A); exp_q.push_back(8'h01); exp_q.push_back(8'h01);
        exp_q.push_back(8'h0A); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        exp_q.push_back({7'b0, p});
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    endtask

    task automatic start_rec();
        wcount = 0;
        push_header(audio_in);
        recording = 1'b1;
        wait_clk(1);
        check("busy after start", 32'(busy), 32'd1);
    endtask

    task automatic wait_idle(input string name, input int max);
        int n;
        n = 0;
        while (busy && n < max) begin
            wait_clk(1);
            n++;
        end
        check({name, " busy low"}, 32'(busy), 32'd0);
    endtask

    // RAM slot: 2 clk high, 2 clk low; a write is taken just before the slot closes
    initial begin : io_drv
        logic [7:0] e;
        forever begin
            if (io_en) begin
                iocycle = 1'b1;
                wait_clk(2);
                if (wr) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected write: addr %0h data %0h, expected none", a, d);
                    end else begin
                        e = exp_q.pop_front();
                        check("write data", 32'(d), 32'(e));
                        check("write addr", 32'(a), 32'(BASE) + 32'(wcount));
                    end
                    wcount++;
                end
                if (wr2) cap_wcount++;
                iocycle = 1'b0;
                wait_clk(2);
            end else begin
                wait_clk(1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        seg_t segs [15];
        int   npulse;
        int   n;

        for (int i = 0; i < 10; i++) segs[i] = '{(i == 0) ? 52 : 50, 1, 40'h05};
        segs[10] = '{3000, 5, 40'h00_00_01_2C_00};
        segs[11] = '{50,   1, 40'h05};
        segs[12] = '{20,   1, 40'h02};
        segs[13] = '{2560, 5, 40'h00_00_01_00_00};
        segs[14] = '{2550, 1, 40'hFF};

        wait_clk(2);
        check("reset wr", 32'(wr), 32'd0);
        check("reset a", 32'(a), 32'(BASE));
        check("reset d", 32'(d), 32'd0);
        check("reset size", 32'(size), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        wait_clk(3);

        // header, square wave and long runs in one image
        io_en = 1'b1;
        npulse = 0;
        start_rec();
        for (int i = 0; i < 15; i++) begin
            wait_clk(segs[i].gap);
            audio_in = ~audio_in;
            for (int k = 0; k < segs[i].nb; k++) exp_q.push_back(segs[i].b[k]);
            npulse += segs[i].nb;
        end
        wait_clk(50);
        recording = 1'b0;
        exp_q.push_back(8'h05);
        npulse++;
        wait_idle("square", 3000);
        check("square size", 32'(size), 32'(32 + npulse));
        check("square overflow", 32'(overflow), 32'd0);
        check("square leftover", 32'(exp_q.size()), 32'd0);

        // overflow with the RAM slot held off
        io_en = 1'b0;
        wait_clk(6);
        start_rec();
        for (int i = 0; i < 40; i++) begin
            wait_clk((i == 0) ? 52 : 10);
            audio_in = ~audio_in;
            if (i < 16) exp_q.push_back((i == 0) ? 8'h05 : 8'h01);
        end
        wait_clk(28);
        recording = 1'b0;
        wait_clk(20);
        check("ovf flag", 32'(overflow), 32'd1);
        check("ovf busy", 32'(busy), 32'd1);
        check("ovf size before drain", 32'(size), 32'd0);
        io_en = 1'b1;
        wait_idle("ovf", 2000);
        check("ovf size", 32'(size), 32'd48);
        check("ovf flag kept", 32'(overflow), 32'd1);
        check("ovf leftover", 32'(exp_q.size()), 32'd0);

        // asynchronous reset mid-record, then a fresh image
        start_rec();
        wait_clk(200);
        check("pre-reset busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async wr", 32'(wr), 32'd0);
        check("async a", 32'(a), 32'(BASE));
        check("async d", 32'(d), 32'd0);
        check("async size", 32'(size), 32'd0);
        check("async busy", 32'(busy), 32'd0);
        check("async overflow", 32'(overflow), 32'd0);
        exp_q.delete();
        recording = 1'b0;
        wait_clk(2);
        reset = 1'b0;
        wait_clk(2);
        start_rec();
        wait_clk(45);
        recording = 1'b0;
        exp_q.push_back(8'h04);
        wait_idle("restart", 2000);
        check("restart size", 32'(size), 32'd33);
        check("restart leftover", 32'(exp_q.size()), 32'd0);

        // capacity limit on the second instance
        cap_wcount = 0;
        recording2 = 1'b1;
        wait_clk(1);
        for (int i = 0; i < 5; i++) begin
            wait_clk((i == 0) ? 52 : 50);
            audio_in = ~audio_in;
        end
        wait_clk(50);
        recording2 = 1'b0;
        n = 0;
        wait_clk(2);
        while (busy2 && n < 2000) begin
            wait_clk(1);
            n++;
        end
        check("cap busy low", 32'(busy2), 32'd0);
        wait_clk(4);
        check("cap writes", 32'(cap_wcount), 32'd34);
        check("cap size", 32'(size2), 32'd34);
        check("cap overflow", 32'(overflow2), 32'd1);
        check("main idle writes", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
